// File: rtl/interboard_receiver.sv
// interboard_receiver: receive side of the 4-phase Request/Ack board link.
// Rebuilds 2-beat frames (header, payload) into one message for the game controller.
//
// Ports:
//   clk                 system clock
//   rst                 asynchronous reset, active low
//   Request_in          peer request, asynchronous to clk
//   inter_data_in[5:0]  peer beat; bit5=1 header (type in [2:0]), bit5=0 payload (number in [4:0])
//   Ack_out             acknowledge back to the peer
//   interboard_en       1-cycle pulse: a complete message is valid
//   interboard_msg_type message type, held until the next message
//   interboard_number   message number, held until the next message
//   interboard_rst      1-cycle pulse with interboard_en when the type is RST_TYPE
//   frame_error         1-cycle pulse on a framing violation or payload timeout
//   busy                high whenever the FSM is not idle
module interboard_receiver #(
    parameter int         SYNC_STAGES    = 2,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [2:0] RST_TYPE       = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Request_in,
    input  logic [5:0] inter_data_in,
    output logic       Ack_out,
    output logic       interboard_en,
    output logic [2:0] interboard_msg_type,
    output logic [4:0] interboard_number,
    output logic       interboard_rst,
    output logic       frame_error,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        HDR_ACK,
        WAIT_PAY,
        PAY_ACK
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             type_lat_q, type_lat_d;
    logic [2:0]             msg_type_q, msg_type_d;
    logic [4:0]             number_q, number_d;
    logic                   ack_q, ack_d;
    logic                   en_q, en_d;
    logic                   irst_q, irst_d;
    logic                   ferr_q, ferr_d;
    logic                   req_s;
    logic                   is_hdr;

    assign req_s  = sync_q[SYNC_STAGES-1];
    assign is_hdr = inter_data_in[5];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], Request_in};

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        type_lat_d = type_lat_q;
        msg_type_d = msg_type_q;
        number_d   = number_q;
        ack_d      = ack_q;
        en_d       = 1'b0;
        irst_d     = 1'b0;
        ferr_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_s) begin
                    ack_d = 1'b1;
                    if (is_hdr) begin
                        type_lat_d = inter_data_in[2:0];
                        state_d    = HDR_ACK;
                    end else begin
                        // orphan payload: still complete the handshake
                        ferr_d  = 1'b1;
                        state_d = PAY_ACK;
                    end
                end
            end
            HDR_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    timer_d = '0;
                    state_d = WAIT_PAY;
                end
            end
            WAIT_PAY: begin
                timer_d = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
                // a request seen on the timeout cycle takes priority
                if (req_s) begin
                    ack_d = 1'b1;
                    if (is_hdr) begin
                        ferr_d     = 1'b1;
                        type_lat_d = inter_data_in[2:0];
                        state_d    = HDR_ACK;
                    end else begin
                        msg_type_d = type_lat_q;
                        number_d   = inter_data_in[4:0];
                        en_d       = 1'b1;
                        irst_d     = (type_lat_q == RST_TYPE);
                        state_d    = PAY_ACK;
                    end
                end else if (timer_q >= T_LAST) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            PAY_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            timer_q    <= '0;
            type_lat_q <= '0;
            msg_type_q <= '0;
            number_q   <= '0;
            ack_q      <= 1'b0;
            en_q       <= 1'b0;
            irst_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            timer_q    <= timer_d;
            type_lat_q <= type_lat_d;
            msg_type_q <= msg_type_d;
            number_q   <= number_d;
            ack_q      <= ack_d;
            en_q       <= en_d;
            irst_q     <= irst_d;
            ferr_q     <= ferr_d;
        end
    end

    assign Ack_out             = ack_q;
    assign interboard_en       = en_q;
    assign interboard_msg_type = msg_type_q;
    assign interboard_number   = number_q;
    assign interboard_rst      = irst_q;
    assign frame_error         = ferr_q;
    assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_interboard_receiver.sv
// tb_interboard_receiver: directed and random frames against a frame-level model.
// Pulses are counted by a monitor; each beat is compared with model expectations.
module tb_interboard_receiver;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Request_in = 1'b0;
    logic [5:0] inter_data_in = 6'd0;
    logic       Ack_out;
    logic       interboard_en;
    logic [2:0] interboard_msg_type;
    logic [4:0] interboard_number;
    logic       interboard_rst;
    logic       frame_error;
    logic       busy;

    interboard_receiver #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TMO),
        .RST_TYPE      (3'd7)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .Request_in         (Request_in),
        .inter_data_in      (inter_data_in),
        .Ack_out            (Ack_out),
        .interboard_en      (interboard_en),
        .interboard_msg_type(interboard_msg_type),
        .interboard_number  (interboard_number),
        .interboard_rst     (interboard_rst),
        .frame_error        (frame_error),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    int en_cnt = 0;
    int rst_cnt = 0;
    int ferr_cnt = 0;
    int coinc_bad = 0;

    always @(negedge clk) begin
        if (interboard_en) en_cnt++;
        if (interboard_rst) rst_cnt++;
        if (frame_error) ferr_cnt++;
        if (interboard_rst && !interboard_en) coinc_bad++;
    end

    // frame-level model
    logic       m_pending = 1'b0;
    logic [2:0] m_type_lat = 3'd0;
    logic [2:0] m_type = 3'd0;
    logic [4:0] m_num = 5'd0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_beat(input logic [5:0] d, output int rlat,
                           output int flat, output logic en_rise);
        @(negedge clk);
        inter_data_in = d;
        Request_in    = 1'b1;
        rlat = 0;
        while (!Ack_out && rlat < 20) begin
            @(posedge clk);
            #1;
            rlat++;
        end
        en_rise = interboard_en;
        Request_in    = 1'b0;
        inter_data_in = 6'($urandom);
        flat = 0;
        while (Ack_out && flat < 20) begin
            @(posedge clk);
            #1;
            flat++;
        end
    endtask

    task automatic beat_chk(input logic [5:0] d);
        int   e0, f0, r0, rl, fl;
        logic er;
        logic x_en, x_ferr, x_rst;
        e0 = en_cnt;
        f0 = ferr_cnt;
        r0 = rst_cnt;
        x_en = 1'b0;
        x_ferr = 1'b0;
        x_rst = 1'b0;
        if (d[5]) begin
            x_ferr     = m_pending;
            m_type_lat = d[2:0];
            m_pending  = 1'b1;
        end else if (m_pending) begin
            x_en      = 1'b1;
            x_rst     = (m_type_lat == 3'd7);
            m_type    = m_type_lat;
            m_num     = d[4:0];
            m_pending = 1'b0;
        end else begin
            x_ferr = 1'b1;
        end
        do_beat(d, rl, fl, er);
        chk("rise_lat", rl, 3);
        chk("fall_lat", fl, 3);
        chk("en_at_ack_rise", er, x_en);
        chk("en_pulses", en_cnt - e0, x_en);
        chk("rst_pulses", rst_cnt - r0, x_rst);
        chk("ferr_pulses", ferr_cnt - f0, x_ferr);
        chk("msg_type", interboard_msg_type, m_type);
        chk("number", interboard_number, m_num);
        chk("busy", busy, m_pending);
    endtask

    task automatic gap_chk(input int cyc);
        int f0;
        logic x_to;
        f0 = ferr_cnt;
        x_to = m_pending && (cyc >= TMO + 4);
        repeat (cyc) begin
            @(posedge clk);
            #1;
        end
        if (x_to) m_pending = 1'b0;
        chk("gap_ferr", ferr_cnt - f0, x_to);
        chk("gap_busy", busy, m_pending);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, e0, f0, r0, rl, fl;
        logic er;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", Ack_out, 0);
        chk("rst_en", interboard_en, 0);
        chk("rst_type", interboard_msg_type, 0);
        chk("rst_num", interboard_number, 0);
        chk("rst_irst", interboard_rst, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;

        beat_chk(6'h22); gap_chk(2);
        beat_chk(6'h11); gap_chk(1);
        beat_chk(6'h27); gap_chk(0);
        beat_chk(6'h00); gap_chk(3);
        beat_chk(6'h05); gap_chk(2);
        beat_chk(6'h21); gap_chk(1);
        beat_chk(6'h23); gap_chk(2);
        beat_chk(6'h1F); gap_chk(2);

        // exact timeout distance from header ack fall
        beat_chk(6'h21);
        n = 0;
        while (!frame_error && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("timeout_lat", n, TMO);
        m_pending = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("timeout_busy", busy, 0);
        beat_chk(6'h04); gap_chk(2);

        // reset while in PAY_ACK with the request held
        beat_chk(6'h22); gap_chk(1);
        @(negedge clk);
        inter_data_in = 6'h11;
        Request_in    = 1'b1;
        n = 0;
        while (!Ack_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_rst_en", interboard_en, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_ack", Ack_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_en", interboard_en, 0);
        chk("mid_rst_type", interboard_msg_type, 0);
        chk("mid_rst_num", interboard_number, 0);
        m_pending = 1'b0;
        m_type    = 3'd0;
        m_num     = 5'd0;
        repeat (3) @(posedge clk);
        e0 = en_cnt;
        f0 = ferr_cnt;
        r0 = rst_cnt;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (!Ack_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("post_rst_lat", n, 3);
        Request_in = 1'b0;
        n = 0;
        while (Ack_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("post_rst_fall", n, 3);
        chk("post_rst_ferr", ferr_cnt - f0, 1);
        chk("post_rst_en", en_cnt - e0, 0);
        chk("post_rst_irst", rst_cnt - r0, 0);
        chk("post_rst_type", interboard_msg_type, m_type);
        chk("post_rst_num", interboard_number, m_num);
        chk("post_rst_busy", busy, 0);

        for (int i = 0; i < 80; i++) begin
            logic [5:0] d;
            d = 6'($urandom);
            if ($urandom_range(0, 3) == 0) d[2:0] = 3'd7;
            beat_chk(d);
            if ($urandom_range(0, 6) == 0) gap_chk($urandom_range(TMO + 4, TMO + 10));
            else gap_chk($urandom_range(0, 4));
        end

        // unused locals from do_beat path kept explicit
        do_beat(6'h20, rl, fl, er);
        chk("final_hdr_lat", rl, 3);
        m_pending = 1'b1;
        gap_chk(TMO + 6);

        chk("rst_without_en", coinc_bad, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
